// File: rtl/lsu_pkg.sv
// Shared encodings and FSM state type for the load/store unit.
// Imported by lsu_ctrl and lsu_align.
package lsu_pkg;

  localparam int TIMEOUT_DEF = 255;

  localparam logic [2:0] MM_B  = 3'b000;
  localparam logic [2:0] MM_H  = 3'b001;
  localparam logic [2:0] MM_W  = 3'b010;
  localparam logic [2:0] MM_BU = 3'b011;
  localparam logic [2:0] MM_HU = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  function automatic logic is_half(input logic [2:0] m);
    return (m == MM_H) || (m == MM_HU);
  endfunction

  function automatic logic is_word(input logic [2:0] m);
    return m == MM_W;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store lane replication,
// and load shift plus sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  mode_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] sh;

  assign sh = rdata_i >> {off_i, 3'b000};

  // Unlisted encodings fall back to full-word behaviour.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = sh;
    case (mode_i)
      MM_B: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sh[7]}}, sh[7:0]};
      end
      MM_BU: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, sh[7:0]};
      end
      MM_H: begin
        be_o    = 4'b0011 << {off_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sh[15]}}, sh[15:0]};
      end
      MM_HU: begin
        be_o    = 4'b0011 << {off_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'h0, sh[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one outstanding bus access, pipeline stall,
// alignment check and wait-timeout abort.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  mem_mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [15:0] TO = 16'(TIMEOUT);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  mode_q, mode_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;
  logic        req;
  logic        start;
  logic [31:0] ld_data;

  assign req = rd_en | wr_en;
  assign misaligned = req &&
    ((is_half(mem_mode) && addr[0]) ||
     (is_word(mem_mode) && (addr[1:0] != 2'b00)));
  assign start = (state_q == S_IDLE) && req && !misaligned;
  assign cnt_inc = cnt_q + 16'd1;

  lsu_align u_align (
    .mode_i  (mode_q),
    .off_i   (addr_q[1:0]),
    .wdata_i (wdata_q),
    .rdata_i (bus_rdata),
    .be_o    (bus_be),
    .wdata_o (bus_wdata),
    .rdata_o (ld_data)
  );

  assign bus_addr = {addr_q[31:2], 2'b00};
  assign bus_we   = we_q;
  assign bus_err  = err_q;
  assign rdata    = (state_q == S_DONE) ? rdata_q : 32'h0;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    stall     = 1'b0;
    bus_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall = start;
        if (start) begin
          state_d = S_REQ;
          addr_d  = addr;
          mode_d  = mem_mode;
          wdata_d = wdata;
          we_d    = wr_en;
          rdata_d = 32'h0;
          cnt_d   = 16'h0;
        end
      end
      S_REQ: begin
        stall     = 1'b1;
        bus_valid = 1'b1;
        cnt_d     = cnt_inc;
        // An accepted handshake beats a coincident timeout.
        if (bus_ready) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (cnt_inc == TO) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_inc;
        if (bus_rvalid) begin
          state_d = S_DONE;
          rdata_d = ld_data;
        end else if (cnt_inc == TO) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      mode_q  <= MM_B;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      rdata_q <= 32'h0;
      cnt_q   <= 16'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: bus responder with programmable
// ready/rvalid latency, alignment, timeout and reset cases.
module tb_lsu_ctrl;

  localparam int TMO = 255;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [2:0]  mem_mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        misaligned;
  logic        bus_err;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          stl;
  } exp_t;

  exp_t sbq[$];

  lsu_ctrl #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .mem_mode   (mem_mode),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .rdata      (rdata),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic we, input logic [2:0] md,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rw, input int rlat,
                                 input int vlat);
    exp_t e;
    logic [1:0]  o;
    logic [7:0]  b;
    logic [15:0] h;
    o = a[1:0];
    b = rw[8*o +: 8];
    h = o[1] ? rw[31:16] : rw[15:0];
    e.we   = we;
    e.addr = a & 32'hFFFF_FFFC;
    e.err  = 1'b0;
    e.be   = 4'h0;
    case (md)
      3'd0, 3'd3: begin
        e.be[o] = 1'b1;
        e.wd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        e.rd = (md == 3'd0) ? {{24{b[7]}}, b} : {24'h0, b};
      end
      3'd1, 3'd4: begin
        e.be = o[1] ? 4'b1100 : 4'b0011;
        e.wd = {wd[15:0], wd[15:0]};
        e.rd = (md == 3'd1) ? {{16{h[15]}}, h} : {16'h0, h};
      end
      default: begin
        e.be = 4'hF;
        e.wd = wd;
        e.rd = rw;
      end
    endcase
    if (we) e.rd = 32'h0;
    e.stl = we ? 2 + rlat : 3 + rlat + vlat;
    if (rlat < 0) begin
      e.stl = 1 + TMO;
      e.err = 1'b1;
      e.rd  = 32'h0;
    end
    return e;
  endfunction

  // rlat < 0 means the bus never accepts.
  task automatic access(input logic we, input logic [2:0] md,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rw, input int rlat,
                        input int vlat, input bit junk);
    exp_t e;
    exp_t f;
    int n;
    int ph;
    int stl;
    int cyc;
    sbq.push_back(model(we, md, a, wd, rw, rlat, vlat));
    @(negedge clk);
    rd_en = !we;
    wr_en = we;
    mem_mode = md;
    addr = a;
    wdata = wd;
    #1;
    chk("mis_clr", {31'h0, misaligned}, 32'h0);
    stl = stall ? 1 : 0;
    @(negedge clk);
    rd_en = 1'b0;
    wr_en = 1'b0;
    addr = 32'h0;
    wdata = 32'h0;
    ph = 0;
    n = 0;
    cyc = 0;
    f = sbq[0];
    while (stall && cyc < 400) begin
      stl++;
      bus_ready = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata = 32'hBAD0_BAD0;
      if (ph == 0) begin
        if (n == rlat) begin
          bus_ready = 1'b1;
          chk("bus_valid", {31'h0, bus_valid}, 32'h1);
          chk("bus_addr", bus_addr, f.addr);
          chk("bus_be", {28'h0, bus_be}, {28'h0, f.be});
          chk("bus_we", {31'h0, bus_we}, {31'h0, f.we});
          if (we) chk("bus_wdata", bus_wdata, f.wd);
          ph = we ? 2 : 1;
          n = 0;
        end else begin
          bus_rvalid = junk;
          n++;
        end
      end else if (ph == 1) begin
        if (n == vlat) begin
          bus_rvalid = 1'b1;
          bus_rdata = rw;
          ph = 2;
        end else begin
          n++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus_ready = 1'b0;
    bus_rvalid = 1'b0;
    if (cyc >= 400) chk("done_tmo", {31'h0, stall}, 32'h0);
    e = sbq.pop_front();
    chk("stall_cyc", 32'(stl), 32'(e.stl));
    chk("rdata", rdata, e.rd);
    chk("bus_err", {31'h0, bus_err}, {31'h0, e.err});
    chk("done_valid", {31'h0, bus_valid}, 32'h0);
    @(negedge clk);
    chk("err_pulse", {31'h0, bus_err}, 32'h0);
    chk("idle_stall", {31'h0, stall}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  md;
    logic [31:0] a;
    logic        we;
    rst = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    mem_mode = 3'd0;
    addr = 32'h0;
    wdata = 32'h0;
    bus_ready = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata = 32'h0;
    #2 rst = 1'b1;
    #1;
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_valid", {31'h0, bus_valid}, 32'h0);
    chk("rst_err", {31'h0, bus_err}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    access(1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0);
    access(1'b0, 3'd0, 32'h203, 32'h0, 32'h80000000, 0, 0, 1'b0);
    access(1'b0, 3'd3, 32'h203, 32'h0, 32'h80000000, 0, 0, 1'b0);
    access(1'b0, 3'd2, 32'h40, 32'h0, 32'h12345678, 0, 0, 1'b0);
    access(1'b0, 3'd1, 32'h1002, 32'h0, 32'h9ABC1234, 2, 3, 1'b1);
    access(1'b0, 3'd4, 32'h1002, 32'h0, 32'h9ABC1234, 1, 1, 1'b1);
    access(1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 1, 0, 1'b0);
    access(1'b1, 3'd1, 32'h200, 32'h0000BEEF, 32'h0, 3, 0, 1'b1);

    @(negedge clk);
    rd_en = 1'b1;
    mem_mode = 3'd1;
    addr = 32'h101;
    #1;
    chk("mis_lh", {31'h0, misaligned}, 32'h1);
    chk("mis_stall", {31'h0, stall}, 32'h0);
    chk("mis_rdata", rdata, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("mis_novalid", {31'h0, bus_valid}, 32'h0);
    end
    rd_en = 1'b0;
    wr_en = 1'b1;
    mem_mode = 3'd2;
    addr = 32'h106;
    #1;
    chk("mis_sw", {31'h0, misaligned}, 32'h1);
    @(negedge clk);
    chk("mis_sw_nv", {31'h0, bus_valid}, 32'h0);
    wr_en = 1'b0;

    access(1'b0, 3'd2, 32'h500, 32'h0, 32'h0, -1, 0, 1'b0);

    @(negedge clk);
    rd_en = 1'b1;
    mem_mode = 3'd2;
    addr = 32'h300;
    @(negedge clk);
    rd_en = 1'b0;
    chk("rq_valid", {31'h0, bus_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_req_valid", {31'h0, bus_valid}, 32'h0);
    chk("rst_req_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    rd_en = 1'b1;
    mem_mode = 3'd2;
    addr = 32'h300;
    @(negedge clk);
    rd_en = 1'b0;
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    chk("wt_stall", {31'h0, stall}, 32'h1);
    chk("wt_valid", {31'h0, bus_valid}, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("rst_wt_stall", {31'h0, stall}, 32'h0);
    chk("rst_wt_valid", {31'h0, bus_valid}, 32'h0);
    chk("rst_wt_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    access(1'b1, 3'd1, 32'h2, 32'h00001234, 32'h0, 0, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      md = 3'($urandom_range(0, 4));
      we = (md <= 3'd2) && ($urandom_range(0, 1) == 1);
      a = $urandom;
      if (md == 3'd1 || md == 3'd4) a[0] = 1'b0;
      if (md == 3'd2) a[1:0] = 2'b00;
      access(we, md, a, $urandom, $urandom, $urandom_range(0, 3),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, maximum bus wait in cycles before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 rd_en  input  1  load request from decoder.
REQ-005 wr_en  input  1  store request from decoder; wins if rd_en also high.
REQ-006 mem_mode  input  3  000 LB, 001 LH, 010 LW/SW, 011 LBU, 100 LHU; 000/001 also SB/SH.
REQ-007 addr  input  32  byte address from ALU.
REQ-008 wdata  input  32  store data (rs2), LSB-justified.
REQ-009 stall  output  1  freeze PC/regfile while an access is in flight.
REQ-010 rdata  output  32  extended load result, valid in DONE.
REQ-011 misaligned  output  1  combinational alignment fault for the current request.
REQ-012 bus_err  output  1  one-cycle pulse on timeout abort.
REQ-013 bus_valid  output  1  bus request, held until accepted.
REQ-014 bus_ready  input  1  bus accepts request when high with bus_valid.
REQ-015 bus_we  output  1  1 = write.
REQ-016 bus_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-017 bus_be  output  4  byte enables.
REQ-018 bus_wdata  output  32  lane-placed store data.
REQ-019 bus_rvalid  input  1  read data valid.
REQ-020 bus_rdata  input  32  read word.

Function
REQ-021 FSM states IDLE, REQ, WAIT, DONE.
REQ-022 misaligned = request && ((half && addr[0]) || (word && addr[1:0]!=0)); a misaligned request issues no bus access, keeps the FSM in IDLE, drives rdata 0 and deasserts stall.
REQ-023 IDLE: an aligned rd_en or wr_en registers addr, mem_mode, wdata and the write flag, moves to REQ, and asserts stall combinationally in the same cycle.
REQ-024 REQ: bus_valid=1 with stable bus_we/addr/be/wdata; on bus_ready a write goes to DONE and a read goes to WAIT.
REQ-025 WAIT: on bus_rvalid, capture extended data and go to DONE; bus_rvalid outside WAIT is ignored.
REQ-026 DONE: stall=0 for exactly one cycle, rdata holds the result, then unconditional return to IDLE with no re-issue.
REQ-027 stall=1 in REQ and WAIT, and in IDLE per REQ-023; otherwise 0.
REQ-028 Byte enables: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111; these apply to reads too.
REQ-029 Store data: byte replicated to all four lanes; half replicated to both halves; word unchanged.
REQ-030 Load extraction: shift bus_rdata right by addr[1:0]*8, then sign-extend for 000/001 and zero-extend for 011/100; word passes through.
REQ-031 A 16-bit wait counter clears on REQ entry and increments in REQ and WAIT; when it reaches TIMEOUT the FSM goes to DONE, bus_err pulses for one cycle and rdata is 0.
REQ-032 Minimum latency: store 2 cycles stalled (IDLE, REQ with ready); load 3 cycles (rvalid in the cycle after acceptance).

Reset
REQ-033 rst forces IDLE asynchronously, including mid-access; bus_valid, stall, bus_err, rdata, and the counter go to 0 immediately.
REQ-034 After reset release, the first request is handled per REQ-023 with no residual state.

Structure
REQ-035 Package lsu_pkg holds the mem_mode encodings, the state enum, and the TIMEOUT default.
REQ-036 Sub-module lsu_align is combinational: byte enables, store lane placement, and load extraction.

Verification
REQ-037 SW addr 0x104, wdata 0xDEADBEEF, bus_ready at first REQ cycle -> bus_be 1111, bus_addr 0x104, stall high for 2 cycles.
REQ-038 LB addr 0x203, bus_rdata 0x80000000 -> rdata 0xFFFFFF80; LBU same stimulus -> 0x00000080.
REQ-039 LH addr 0x101 -> misaligned=1, bus_valid never asserted, stall 0.
REQ-040 LW with bus_ready held low -> bus_err pulse after 255 wait cycles, rdata 0, FSM back in IDLE.
REQ-041 rst asserted in WAIT -> bus_valid and stall drop without a clock edge; the next SH addr 0x2 gives bus_be 1100.
